// File: rtl/ppu_line_writer.sv
// ppu_line_writer: maps BG FIFO colour indices through BGP into a 160x144 frame buffer, pads short lines, flags frame end; PPU_LW_DBUF_EN adds a second bank.
module ppu_line_writer #(
    parameter int         LCD_W     = 160,
    parameter int         LCD_H     = 144,
    parameter logic [1:0] PAD_SHADE = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_px_in,
    input  logic        i_px_valid,
    input  logic [1:0]  i_ppu_mode,
    input  logic [7:0]  i_ly,
    input  logic [7:0]  i_bgp,
    input  logic        i_lcd_en,
    output logic        o_fb_we,
`ifdef PPU_LW_DBUF_EN
    output logic [15:0] o_fb_addr,
`else
    output logic [14:0] o_fb_addr,
`endif
    output logic [1:0]  o_fb_data,
    output logic        o_frame_done,
    output logic        o_line_ovf,
    output logic        o_disp_bank
);
    localparam logic [7:0] W8 = 8'(LCD_W);
    localparam logic [7:0] H8 = 8'(LCD_H);

    typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DONE} state_t;

    state_t                      r_state;
    logic [1:0]                  r_prev_mode;
    logic [7:0]                  r_x;
    logic [14:0]                 r_row_base;
    logic                        r_armed, r_we, r_done, r_ovf, r_bank;
    logic [$bits(o_fb_addr)-1:0] r_addr;
    logic [1:0]                  r_data;
    logic                        w_draw, w_start, w_px_wr, w_pad_wr, w_fd;
    logic [14:0]                 w_lin;
    logic [$bits(o_fb_addr)-1:0] w_wr_addr;

    assign w_draw   = i_ppu_mode == 2'd3;
    assign w_start  = w_draw && r_prev_mode != 2'd3 && i_ly < H8;
    assign w_px_wr  = r_state == ACTIVE && w_draw && i_px_valid;
    assign w_pad_wr = r_state == PAD;
    // Hold frame_done back while a line is still being written so the last write always leads it
    assign w_fd     = r_armed && i_ly >= H8 && (r_state == IDLE || r_state == DONE);
    assign w_lin    = r_row_base + {7'd0, r_x};
`ifdef PPU_LW_DBUF_EN
    assign w_wr_addr   = {~r_bank, w_lin};
    assign o_disp_bank = r_bank;
`else
    assign w_wr_addr   = w_lin;
    assign o_disp_bank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prev_mode <= 2'd0;
            r_x         <= 8'd0;
            r_row_base  <= 15'd0;
            r_armed     <= 1'b1;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_bank      <= 1'b0;
            r_addr      <= '0;
            r_data      <= 2'd0;
        end else begin
            r_prev_mode <= i_ppu_mode;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            if (!i_lcd_en) begin
                r_state <= IDLE;
                r_armed <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: if (w_start) begin
                        r_state    <= ACTIVE;
                        r_x        <= 8'd0;
                        r_row_base <= ({7'd0, i_ly} << 7) + ({7'd0, i_ly} << 5);
                    end
                    ACTIVE: if (!w_draw) r_state <= PAD;
                    else if (i_px_valid) begin
                        r_x     <= r_x + 8'd1;
                        r_state <= r_x == W8 - 8'd1 ? DONE : ACTIVE;
                    end
                    PAD: begin
                        r_x     <= r_x + 8'd1;
                        r_state <= r_x == W8 - 8'd1 ? DONE : PAD;
                    end
                    DONE: if (!w_draw) r_state <= IDLE;
                    else if (i_px_valid) r_ovf <= 1'b1;
                endcase
                if (w_px_wr || w_pad_wr) begin
                    r_we   <= 1'b1;
                    r_addr <= w_wr_addr;
                    r_data <= w_pad_wr ? PAD_SHADE : i_bgp[{i_px_in, 1'b0} +: 2];
                end
                if (w_fd) begin
                    r_done  <= 1'b1;
                    r_armed <= 1'b0;
                    r_bank  <= ~r_bank;
                end
            end
            if (i_ly == 8'd0) begin
                r_armed <= 1'b1;
                r_ovf   <= 1'b0;
            end
        end
    end

    assign o_fb_we      = r_we;
    assign o_fb_addr    = r_addr;
    assign o_fb_data    = r_data;
    assign o_frame_done = r_done;
    assign o_line_ovf   = r_ovf;
endmodule

// File: tb/tb_ppu_line_writer.sv
// tb_ppu_line_writer: randomized line/frame scenarios checked against a frame-buffer write model.
module tb_ppu_line_writer;
`ifdef PPU_LW_DBUF_EN
    localparam int AW = 16;
`else
    localparam int AW = 15;
`endif
    logic          clk = 1'b0, rst = 1'b1;
    logic [1:0]    i_px_in = 2'd0, i_ppu_mode = 2'd0;
    logic          i_px_valid = 1'b0, i_lcd_en = 1'b1;
    logic [7:0]    i_ly = 8'd0, i_bgp = 8'hE4;
    logic          o_fb_we, o_frame_done, o_line_ovf, o_disp_bank;
    logic [AW-1:0] o_fb_addr;
    logic [1:0]    o_fb_data;
    int chk = 0, pass = 0, cyc = 0, fd_cnt = 0, fd_cyc = 0, last_we_cyc = 0, bank = 0, d;
    int exp_q[$], got_q[$];

    always #5 clk = ~clk;

    ppu_line_writer dut (
        .clk(clk), .rst(rst), .i_px_in(i_px_in), .i_px_valid(i_px_valid),
        .i_ppu_mode(i_ppu_mode), .i_ly(i_ly), .i_bgp(i_bgp), .i_lcd_en(i_lcd_en),
        .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr), .o_fb_data(o_fb_data),
        .o_frame_done(o_frame_done), .o_line_ovf(o_line_ovf), .o_disp_bank(o_disp_bank)
    );

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (o_fb_we === 1'b1) begin
            got_q.push_back(int'(o_fb_addr) * 4 + int'(o_fb_data));
            last_we_cyc = cyc;
        end
        if (o_frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame-buffer entry: writes target the bank the display is not showing
    function automatic int ent(input int addr, input int data);
        int msb = 0;
`ifdef PPU_LW_DBUF_EN
        msb = (1 - bank) << 15;
`endif
        return (msb + addr) * 4 + data;
    endfunction

    function automatic int qdiff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (got_q[i] != exp_q[i]) return i;
        return -1;
    endfunction

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic begin_line(input int ly);
        i_ly = 8'(ly); i_ppu_mode = 2'd2; i_px_valid = 1'b0; tick();
        i_ppu_mode = 2'd3; tick();
    endtask

    task automatic send_px(input int ly, input int k0, input int n, input bit rnd);
        for (int k = k0; k < n; k++) begin
            if (rnd) repeat ($urandom_range(2)) begin i_px_valid = 1'b0; tick(); end
            i_px_valid = 1'b1;
            if (rnd) begin i_px_in = 2'($urandom); i_bgp = 8'($urandom); end
            if (k < 160) exp_q.push_back(ent(ly * 160 + k, (int'(i_bgp) >> (2 * int'(i_px_in))) & 3));
            tick();
        end
        i_px_valid = 1'b0;
    endtask

    task automatic finish_line(input int ly, input int n, input bit rnd, input int end_ly);
        i_px_valid = 1'b0; i_ppu_mode = 2'd0; i_ly = 8'(end_ly);
        for (int k = n; k < 160; k++) exp_q.push_back(ent(ly * 160 + k, 0));
        repeat (170) begin i_px_valid = rnd ? 1'($urandom) : 1'b0; i_px_in = 2'($urandom); tick(); end
        i_px_valid = 1'b0;
    endtask

    task automatic draw_line(input int ly, input int n, input bit rnd, input int end_ly);
        begin_line(ly);
        send_px(ly, 0, n, rnd);
        finish_line(ly, n, rnd, end_ly);
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) tick();
        chk++; if ({o_fb_we, o_fb_addr, o_fb_data} !== '0) $display("FAIL reset_write: got we=%0b addr=%0d data=%0d, required 0", o_fb_we, o_fb_addr, o_fb_data); else pass++;
        chk++; if ({o_frame_done, o_line_ovf, o_disp_bank} !== 3'b000) $display("FAIL reset_flags: got fd/ovf/bank=%b, required 000", {o_frame_done, o_line_ovf, o_disp_bank}); else pass++;
        rst = 1'b0; tick();
    endtask

    task automatic test_full_line();
        clear_q();
        begin_line(0);
        i_px_in = 2'd1; i_bgp = 8'hE4; i_px_valid = 1'b1;
        exp_q.push_back(ent(0, 1));
        chk++; if (o_fb_we !== 1'b0) $display("FAIL latency_pre: got we=%0b, required 0", o_fb_we); else pass++;
        tick();
        chk++; if (o_fb_we !== 1'b1 || int'(o_fb_addr) * 4 + int'(o_fb_data) != exp_q[0]) $display("FAIL latency_first: got we=%0b addr=%0d data=%0d, required we=1 entry %0d", o_fb_we, o_fb_addr, o_fb_data, exp_q[0]); else pass++;
        send_px(0, 1, 160, 1'b0);
        finish_line(0, 160, 1'b0, 0);
        d = qdiff();
        chk++; if (d != -1) $display("FAIL full_line_fixed: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
        chk++; if (o_line_ovf !== 1'b0) $display("FAIL full_line_ovf: got %0b, required 0", o_line_ovf); else pass++;
        clear_q();
        draw_line(int'($urandom_range(143)), 160, 1'b1, 1);
        d = qdiff();
        chk++; if (d != -1) $display("FAIL full_line_rand: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
    endtask

    task automatic test_short_pad();
        clear_q();
        draw_line(5, 100, 1'b1, 5);
        d = qdiff();
        chk++; if (d != -1) $display("FAIL pad_ly5: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
        for (int i = 0; i < 4; i++) begin
            clear_q();
            draw_line(int'($urandom_range(1, 143)), int'($urandom_range(1, 159)), 1'b1, 1);
            d = qdiff();
            chk++; if (d != -1) $display("FAIL pad_rand%0d: got %0d writes diff at %0d, required %0d writes", i, got_q.size(), d, exp_q.size()); else pass++;
        end
    endtask

    task automatic test_overflow();
        clear_q();
        draw_line(2, 165, 1'b1, 2);
        d = qdiff();
        chk++; if (d != -1) $display("FAIL ovf_writes: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
        chk++; if (got_q.size() == 0 || (got_q[$] >> 2) != (ent(479, 0) >> 2)) $display("FAIL ovf_last_addr: got entry %0d, required addr entry %0d", got_q.size() ? got_q[$] : -1, ent(479, 0)); else pass++;
        chk++; if (o_line_ovf !== 1'b1) $display("FAIL ovf_set: got %0b, required 1", o_line_ovf); else pass++;
        i_ly = 8'd0; tick();
        chk++; if (o_line_ovf !== 1'b0) $display("FAIL ovf_clear: got %0b, required 0", o_line_ovf); else pass++;
    endtask

    task automatic test_palette();
        clear_q();
        begin_line(7);
        i_bgp = 8'h1B;
        for (int p = 0; p < 4; p++) begin
            i_px_in = 2'(p); i_px_valid = 1'b1;
            exp_q.push_back(ent(7 * 160 + p, 3 - p));
            tick();
        end
        finish_line(7, 4, 1'b0, 7);
        for (int p = 0; p < 4; p++) begin
            chk++; if (got_q.size() <= p || (got_q[p] & 3) != 3 - p) $display("FAIL palette_px%0d: got data %0d, required %0d", p, got_q.size() > p ? got_q[p] & 3 : -1, 3 - p); else pass++;
        end
        d = qdiff();
        chk++; if (d != -1) $display("FAIL palette_line: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
    endtask

    task automatic test_frame_done();
        fd_cnt = 0;
        i_ly = 8'd143; repeat (3) tick();
        for (int l = 144; l <= 153; l++) begin i_ly = 8'(l); repeat (3) tick(); end
        chk++; if (fd_cnt != 1) $display("FAIL frame_done_once: got %0d pulses, required 1", fd_cnt); else pass++;
        bank ^= 1;
`ifdef PPU_LW_DBUF_EN
        chk++; if (o_disp_bank !== 1'b1) $display("FAIL disp_bank_toggle: got %0b, required 1", o_disp_bank); else pass++;
`else
        chk++; if (o_disp_bank !== 1'b0) $display("FAIL disp_bank_tied: got %0b, required 0", o_disp_bank); else pass++;
`endif
        clear_q();
        i_ly = 8'd150; i_ppu_mode = 2'd2; tick();
        i_ppu_mode = 2'd3; i_px_valid = 1'b1; repeat (20) tick();
        i_px_valid = 1'b0; i_ppu_mode = 2'd0; repeat (5) tick();
        chk++; if (got_q.size() != 0) $display("FAIL vblank_no_draw: got %0d writes, required 0", got_q.size()); else pass++;
        i_ly = 8'd0; tick();
        clear_q();
        draw_line(0, 40, 1'b1, 0);
        d = qdiff();
        chk++; if (d != -1) $display("FAIL next_frame_bank: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
        i_ly = 8'd144; repeat (3) tick();
        bank ^= 1;
        chk++; if (fd_cnt != 2) $display("FAIL frame_done_rearm: got %0d pulses, required 2", fd_cnt); else pass++;
        i_ly = 8'd0; tick();
    endtask

    task automatic test_back_to_back();
        clear_q(); fd_cnt = 0;
        draw_line(143, 150, 1'b1, 144);
        bank ^= 1;
        d = qdiff();
        chk++; if (d != -1) $display("FAIL last_line_pad: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
        chk++; if (fd_cnt != 1 || fd_cyc <= last_we_cyc) $display("FAIL fd_after_write: got %0d pulses at cycle %0d, last write cycle %0d, required 1 pulse after", fd_cnt, fd_cyc, last_we_cyc); else pass++;
        i_ly = 8'd0; tick();
    endtask

    task automatic test_rst_midline();
        clear_q();
        begin_line(10);
        send_px(10, 0, 80, 1'b1);
        rst = 1'b1; i_ppu_mode = 2'd0; i_px_valid = 1'b1; tick();
        bank = 0;
        chk++; if (o_fb_we !== 1'b0 || o_disp_bank !== 1'b0) $display("FAIL rst_mid_we: got we=%0b bank=%0b, required 0 0", o_fb_we, o_disp_bank); else pass++;
        rst = 1'b0; i_px_valid = 1'b0; repeat (170) tick();
        d = qdiff();
        chk++; if (d != -1) $display("FAIL rst_no_pad: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
        clear_q();
        draw_line(11, 160, 1'b1, 11);
        d = qdiff();
        chk++; if (d != -1) $display("FAIL rst_restart: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
    endtask

    task automatic test_lcd_disable();
        clear_q(); fd_cnt = 0;
        begin_line(20);
        send_px(20, 0, 50, 1'b1);
        i_lcd_en = 1'b0; tick();
        chk++; if (o_fb_we !== 1'b0) $display("FAIL lcd_off_we: got %0b, required 0", o_fb_we); else pass++;
        i_px_valid = 1'b1; repeat (20) tick();
        i_px_valid = 1'b0; i_ly = 8'd150; repeat (150) tick();
        chk++; if (fd_cnt != 0) $display("FAIL lcd_off_no_fd: got %0d pulses, required 0", fd_cnt); else pass++;
        i_ly = 8'd20; i_ppu_mode = 2'd0; tick();
        i_lcd_en = 1'b1; repeat (5) tick();
        d = qdiff();
        chk++; if (d != -1) $display("FAIL lcd_off_no_pad: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
        clear_q();
        draw_line(21, 120, 1'b1, 21);
        d = qdiff();
        chk++; if (d != -1) $display("FAIL lcd_on_restart: got %0d writes diff at %0d, required %0d writes", got_q.size(), d, exp_q.size()); else pass++;
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_short_pad();
        test_overflow();
        test_palette();
        test_frame_done();
        test_back_to_back();
        test_rst_midline();
        test_lcd_disable();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
